// File: rtl/mem_responder.sv
// mem_responder: word-addressed memory responder. Accepts one request per cycle,
// delays each response by LATENCY cycles and returns responses in acceptance order
// through a QDEPTH-entry FIFO with valid/ready backpressure.
// Optional feature: define MEM_RESP_ERR_EN to flag out-of-range addresses with rsp_err.
module mem_responder #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter int unsigned QDEPTH      = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  // Storage (not reset)
  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];

  // Outstanding request count (delay pipe + FIFO)
  logic [CW-1:0]     out_cnt_q, out_cnt_d;

  // Delay pipe
  logic              pipe_v_q    [LATENCY];
  logic [DATA_W-1:0] pipe_data_q [LATENCY];
  logic              pipe_err_q  [LATENCY];

  // Response FIFO
  logic [DATA_W-1:0] fifo_data_q [QDEPTH];
  logic              fifo_err_q  [QDEPTH];
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]     last_ptr;
  logic [PW-1:0]     head_ptr;

  logic              accept;
  logic              pop;
  logic              push;
  logic [AW-1:0]     idx;
  logic              acc_err;
  logic [DATA_W-1:0] acc_data;

  assign req_ready = rst_n && (out_cnt_q < CW'(QDEPTH));
  assign accept    = req_valid && req_ready;
  assign idx       = req_addr[AW-1:0];
  assign push      = pipe_v_q[LATENCY-1];
  assign rsp_valid = (fifo_cnt_q != '0);
  assign pop       = rsp_valid && rsp_ready;

`ifndef MEM_RESP_ERR_EN
  // Upper address bits are ignored when range checking is disabled
  logic unused_addr_hi;
  assign unused_addr_hi = ^(req_addr >> AW);
`endif

  // Classify the request and sample read data at the accept edge
  always_comb begin
    acc_err = 1'b0;
`ifdef MEM_RESP_ERR_EN
    acc_err = ((req_addr >> AW) != '0);
`endif
    acc_data = (req_we || acc_err) ? '0 : mem_q[idx];
  end

  // Storage write port; out-of-range writes are dropped
  always_ff @(posedge clk) begin
    if (accept && req_we && !acc_err) begin
      mem_q[idx] <= req_wdata;
    end
  end

  // Fixed-latency delay pipe carrying response data and error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        pipe_v_q[i]    <= 1'b0;
        pipe_data_q[i] <= '0;
        pipe_err_q[i]  <= 1'b0;
      end
    end else begin
      pipe_v_q[0]    <= accept;
      pipe_data_q[0] <= acc_data;
      pipe_err_q[0]  <= acc_err;
      for (int unsigned i = 1; i < LATENCY; i++) begin
        pipe_v_q[i]    <= pipe_v_q[i-1];
        pipe_data_q[i] <= pipe_data_q[i-1];
        pipe_err_q[i]  <= pipe_err_q[i-1];
      end
    end
  end

  // Next-state for FIFO pointers and occupancy, and outstanding count
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    out_cnt_d  = out_cnt_q;
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(QDEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(QDEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + 1'b1;
      2'b01:   fifo_cnt_d = fifo_cnt_q - 1'b1;
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    case ({accept, pop})
      2'b10:   out_cnt_d = out_cnt_q + 1'b1;
      2'b01:   out_cnt_d = out_cnt_q - 1'b1;
      default: out_cnt_d = out_cnt_q;
    endcase
  end

  // FIFO storage, pointers and outstanding-count registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      fifo_cnt_q <= '0;
      out_cnt_q  <= '0;
      for (int unsigned i = 0; i < QDEPTH; i++) begin
        fifo_data_q[i] <= '0;
        fifo_err_q[i]  <= 1'b0;
      end
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
      out_cnt_q  <= out_cnt_d;
      if (push) begin
        fifo_data_q[wr_ptr_q] <= pipe_data_q[LATENCY-1];
        fifo_err_q[wr_ptr_q]  <= pipe_err_q[LATENCY-1];
      end
    end
  end

  // When empty, present the slot just popped so rsp_rdata keeps its last value;
  // that slot cannot be overwritten until the FIFO is non-empty again.
  always_comb begin
    last_ptr = (rd_ptr_q == '0) ? PW'(QDEPTH - 1) : rd_ptr_q - 1'b1;
    head_ptr = rsp_valid ? rd_ptr_q : last_ptr;
  end

  assign rsp_rdata = fifo_data_q[head_ptr];
  assign rsp_err   = rsp_valid && fifo_err_q[head_ptr];

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: three instances (LATENCY 2, 1, 4) share one stimulus
// stream; a per-instance scoreboard predicts every response at its accept edge.
module tb_mem_responder;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0;
  logic        req_we    = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_ready = 1'b0;

  logic        rdy [NI];
  logic        rv  [NI];
  logic [31:0] rd  [NI];
  logic        re  [NI];

  int lats [NI] = '{2, 1, 4};

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] d;
    logic        e;
    logic        chk;
  } exp_t;

  exp_t        exp_q   [NI][$];
  logic [31:0] mdl_mem [NI][1024];
  logic        mdl_wr  [NI][1024];
  logic        hold_v  [NI];
  logic [31:0] hold_d  [NI];
  logic        hold_e  [NI];
  int          acc_cnt [NI];
  int          rsp_cnt [NI];
  exp_t        mon_e;
  logic [9:0]  mon_idx;
  logic        mon_err;

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(2), .QDEPTH(4)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[0]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[0]), .rsp_ready(rsp_ready),
    .rsp_rdata(rd[0]), .rsp_err(re[0]));

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(1), .QDEPTH(4)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[1]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[1]), .rsp_ready(rsp_ready),
    .rsp_rdata(rd[1]), .rsp_err(re[1]));

  mem_responder #(.ADDR_W(32), .DATA_W(32), .DEPTH_WORDS(1024), .LATENCY(4), .QDEPTH(4)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(rdy[2]), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rv[2]), .rsp_ready(rsp_ready),
    .rsp_rdata(rd[2]), .rsp_err(re[2]));

  // Scoreboard: mid-cycle, predict accepts at the coming edge and check pops/holds
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (!rst_n) begin
        exp_q[k].delete();
        hold_v[k] = 1'b0;
      end else begin
        if (hold_v[k]) begin
          checks++;
          if (rv[k] !== 1'b1 || rd[k] !== hold_d[k] || re[k] !== hold_e[k]) begin
            errors++;
            $display("FAIL hold_stable inst%0d: got v=%b d=%h e=%b, want v=1 d=%h e=%b",
                     k, rv[k], rd[k], re[k], hold_d[k], hold_e[k]);
          end
        end
        hold_v[k] = rv[k] && !rsp_ready;
        hold_d[k] = rd[k];
        hold_e[k] = re[k];
        if (rv[k] && rsp_ready) begin
          checks++;
          if (exp_q[k].size() == 0) begin
            errors++;
            $display("FAIL unexpected_rsp inst%0d: got d=%h e=%b, want no response", k, rd[k], re[k]);
          end else begin
            mon_e = exp_q[k].pop_front();
            rsp_cnt[k]++;
            if (re[k] !== mon_e.e || (mon_e.chk && rd[k] !== mon_e.d)) begin
              errors++;
              $display("FAIL rsp_data inst%0d: got d=%h e=%b, want d=%h e=%b",
                       k, rd[k], re[k], mon_e.d, mon_e.e);
            end
          end
        end
        if (req_valid && rdy[k]) begin
          mon_idx = req_addr[9:0];
          mon_err = 1'b0;
`ifdef MEM_RESP_ERR_EN
          mon_err = (req_addr >= 32'd1024);
`endif
          mon_e.e   = mon_err;
          mon_e.d   = '0;
          mon_e.chk = 1'b1;
          if (!req_we && !mon_err) begin
            mon_e.d   = mdl_mem[k][mon_idx];
            mon_e.chk = mdl_wr[k][mon_idx];
          end
          if (req_we && !mon_err) begin
            mdl_mem[k][mon_idx] = req_wdata;
            mdl_wr[k][mon_idx]  = 1'b1;
          end
          exp_q[k].push_back(mon_e);
          acc_cnt[k]++;
        end
      end
    end
  end

  // Drive one request and hold it until instance 0 accepts (bounded)
  task automatic send(input logic we, input logic [31:0] a, input logic [31:0] d);
    int   n   = 0;
    logic acc = 1'b0;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = rdy[0];
      @(posedge clk);
      #1;
      n++;
    end
    req_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL send_timeout: got no accept after %0d cycles, want accept", n);
    end
  endtask

  task automatic drain;
    int n = 0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size()) != 0 && n < 80) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n >= 80) begin
      errors++;
      $display("FAIL drain_timeout: got %0d/%0d/%0d pending, want 0",
               exp_q[0].size(), exp_q[1].size(), exp_q[2].size());
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (rv[k] !== 1'b0 || rd[k] !== 32'h0 || re[k] !== 1'b0 || rdy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state inst%0d: got v=%b d=%h e=%b rdy=%b, want 0 0 0 0",
                 k, rv[k], rd[k], re[k], rdy[k]);
      end
    end
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (rdy[k] !== 1'b1 || rv[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_release inst%0d: got rdy=%b v=%b, want rdy=1 v=0", k, rdy[k], rv[k]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic;
    int          first [NI];
    int          nhigh [NI];
    logic [31:0] rdat  [NI];
    rsp_ready = 1'b1;
    for (int k = 0; k < NI; k++) begin
      first[k] = -1;
      nhigh[k] = 0;
      rdat[k]  = '0;
    end
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 32'd5;
    req_wdata = 32'hDEADBEEF;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        req_we    = 1'b0;
        req_wdata = '0;
      end
      if (c == 2) req_valid = 1'b0;
      for (int k = 0; k < NI; k++) begin
        if (rv[k]) begin
          if (first[k] < 0) first[k] = c;
          nhigh[k]++;
          if (c == first[k] + 1) rdat[k] = rd[k];
        end
      end
    end
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (first[k] !== 1 + lats[k]) begin
        errors++;
        $display("FAIL latency inst%0d: got first valid cycle %0d, want %0d", k, first[k], 1 + lats[k]);
      end
      checks++;
      if (nhigh[k] !== 2) begin
        errors++;
        $display("FAIL rsp_count inst%0d: got %0d valid cycles, want 2", k, nhigh[k]);
      end
      checks++;
      if (rdat[k] !== 32'hDEADBEEF) begin
        errors++;
        $display("FAIL read_after_write inst%0d: got %h, want deadbeef", k, rdat[k]);
      end
    end
    drain();
  endtask

  task automatic test_full_stall;
    int          nhi = 0;
    logic [31:0] h;
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(1'b1, 32'(8 + i), 32'h1000_0000 + 32'(i));
    drain();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 32'(8 + i), '0);
    checks++;
    if (rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL ready_full: got req_ready=%b after 4 accepts, want 0", rdy[0]);
    end
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'd12;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      if (rdy[0]) nhi++;
    end
    checks++;
    if (nhi !== 0) begin
      errors++;
      $display("FAIL ready_stall: got req_ready high %0d cycles, want 0", nhi);
    end
    h = rd[0];
    checks++;
    if (rv[0] !== 1'b1 || h !== 32'h1000_0000) begin
      errors++;
      $display("FAIL stall_head: got v=%b d=%h, want v=1 d=10000000", rv[0], h);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (rd[0] !== h) begin
      errors++;
      $display("FAIL stall_hold: got %h, want %h", rd[0], h);
    end
    rsp_ready = 1'b1;
    send(1'b0, 32'd12, '0);
    send(1'b0, 32'd13, '0);
    drain();
  endtask

  task automatic test_accept_pop_full;
    int n = 0;
    rsp_ready = 1'b0;
    send(1'b0, 32'd8, '0);
    send(1'b0, 32'd9, '0);
    send(1'b0, 32'd10, '0);
    while (rv[0] !== 1'b1 && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (rv[0] !== 1'b1 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL three_outstanding: got v=%b rdy=%b, want v=1 rdy=1", rv[0], rdy[0]);
    end
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_addr  = 32'd11;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL accept_pop_same_edge: got req_ready=%b, want 1", rdy[0]);
    end
    rsp_ready = 1'b0;
    req_addr  = 32'd12;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    checks++;
    if (rdy[0] !== 1'b0) begin
      errors++;
      $display("FAIL count_after_accept_pop: got req_ready=%b, want 0", rdy[0]);
    end
    drain();
  endtask

  task automatic test_reset_midop;
    int nhi = 0;
    rsp_ready = 1'b0;
    send(1'b0, 32'd8, '0);
    send(1'b0, 32'd9, '0);
    send(1'b1, 32'd20, 32'h5555_AAAA);
    @(posedge clk);
    #1;
    checks++;
    if (rv[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_valid: got v=%b, want 1", rv[0]);
    end
    rst_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (rv[k] !== 1'b0 || rdy[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_midop inst%0d: got v=%b rdy=%b, want 0 0", k, rv[k], rdy[k]);
      end
    end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (rdy[k] !== 1'b1) begin
        errors++;
        $display("FAIL ready_after_release inst%0d: got %b, want 1", k, rdy[k]);
      end
    end
    rsp_ready = 1'b1;
    repeat (10) begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NI; k++) if (rv[k]) nhi++;
    end
    checks++;
    if (nhi !== 0) begin
      errors++;
      $display("FAIL stale_rsp: got %0d valid cycles after reset, want 0", nhi);
    end
  endtask

  task automatic test_addr_error;
    int          n = 0;
    logic        e2 = 1'b0;
    logic        e3 = 1'b0;
    logic [31:0] d3 = '0;
    logic        want_e2;
    logic [31:0] want_d3;
`ifdef MEM_RESP_ERR_EN
    want_e2 = 1'b1;
    want_d3 = 32'h0000_A5A5;
`else
    want_e2 = 1'b0;
    want_d3 = 32'h0000_1234;
`endif
    rsp_ready = 1'b0;
    send(1'b1, 32'd3, 32'h0000_A5A5);
    send(1'b1, 32'd1027, 32'h0000_1234);
    send(1'b0, 32'd3, '0);
    rsp_ready = 1'b1;
    for (int c = 0; c < 20 && n < 3; c++) begin
      if (rv[0]) begin
        n++;
        if (n == 2) e2 = re[0];
        if (n == 3) begin
          e3 = re[0];
          d3 = rd[0];
        end
      end
      @(posedge clk);
      #1;
    end
    checks++;
    if (n !== 3 || e2 !== want_e2) begin
      errors++;
      $display("FAIL oob_write_err: got n=%0d err=%b, want n=3 err=%b", n, e2, want_e2);
    end
    checks++;
    if (d3 !== want_d3 || e3 !== 1'b0) begin
      errors++;
      $display("FAIL oob_write_effect: got d=%h err=%b, want d=%h err=0", d3, e3, want_d3);
    end
    drain();
  endtask

  task automatic test_random;
    logic [31:0] a;
    for (int k = 0; k < NI; k++) begin
      acc_cnt[k] = 0;
      rsp_cnt[k] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      a = 32'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) a = a + 32'd1024;
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = 1'($urandom_range(0, 1));
      req_addr  = a;
      req_wdata = $urandom;
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    drain();
    for (int k = 0; k < NI; k++) begin
      checks++;
      if (rsp_cnt[k] !== acc_cnt[k] || acc_cnt[k] < 50) begin
        errors++;
        $display("FAIL random_stream inst%0d: got %0d responses for %0d accepts, want equal and >=50",
                 k, rsp_cnt[k], acc_cnt[k]);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion by 500us, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < NI; k++) begin
      hold_v[k]  = 1'b0;
      acc_cnt[k] = 0;
      rsp_cnt[k] = 0;
      for (int i = 0; i < 1024; i++) mdl_wr[k][i] = 1'b0;
    end
    test_reset();
    test_basic();
    test_full_stall();
    test_accept_pop_full();
    test_reset_midop();
    test_addr_error();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
